vs_residual_ram_arbiter: RTL and testbench

- Shares the single synchronous residual RAM between up to NUM_REQ requesters, one owner at a time:
  - y->r transfer in the algorithm FSM;
  - dictionary-processor residual reads;
  - residual-update writer in the main loop.
- Arbitration is round-robin with burst lock: an owner keeps the RAM as long as it holds req.
- Muxes the owner's command onto the RAM ports.
- Tags read returns back to the issuing requester one cycle later.

---
 rtl/vs_residual_ram_arbiter_pkg.sv | 19 +
 rtl/vs_residual_ram_arbiter_if.sv | 20 ++
 rtl/vs_residual_ram_arbiter_picker.sv | 27 ++
 rtl/vs_residual_ram_arbiter.sv | 111 +++++++++++
 tb/tb_vs_residual_ram_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vs_residual_ram_arbiter_pkg.sv
// rtl/vs_residual_ram_arbiter_pkg.sv - shared types and helpers for the residual RAM arbiter
package vs_arbiter_pkg;

  localparam int FP_DATA_BUS_WIDTH = 32;
  localparam int ARB_MAX_REQ       = 8;
  localparam int ARB_IDX_W         = $clog2(ARB_MAX_REQ);

  typedef enum logic {ARB_IDLE, ARB_OWNED} arb_state_t;

  function automatic logic [ARB_IDX_W-1:0] onehot_to_index(input logic [ARB_MAX_REQ-1:0] onehot);
    logic [ARB_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_MAX_REQ; i++) begin
      if (onehot[i]) idx = ARB_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vs_residual_ram_arbiter_if.sv
// rtl/vs_residual_ram_arbiter_if.sv - requester-side bus of the residual RAM arbiter
interface vs_residual_ram_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            rvalid;
  logic [DATA_WIDTH-1:0]         rdata;
  logic [NUM_REQ-1:0]            preempt_err;

  modport master (output req, req_we, req_addr, req_wdata,
                  input  gnt, rvalid, rdata, preempt_err);
  modport slave  (input  req, req_we, req_addr, req_wdata,
                  output gnt, rvalid, rdata, preempt_err);
endinterface

// File: rtl/vs_residual_ram_arbiter_picker.sv
// rtl/vs_residual_ram_arbiter_picker.sv - combinational round-robin winner search from last_owner+1
module vs_rr_priority_picker
  import vs_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [ARB_IDX_W-1:0] last_owner,
  output logic [ARB_IDX_W-1:0] winner,
  output logic                 valid
);
  int idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    // last_owner itself is visited last, so it only wins when nobody else asks
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_owner) + k) % NUM_REQ;
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = ARB_IDX_W'(idx);
      end
    end
  end
endmodule

// File: rtl/vs_residual_ram_arbiter.sv
// rtl/vs_residual_ram_arbiter.sv - round-robin burst-lock arbiter for the shared residual RAM
// Optional owner timeout / forced release: VS_RESIDUAL_ARB_TIMEOUT_EN
module vs_residual_ram_arbiter
  import vs_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = FP_DATA_BUS_WIDTH,
  parameter int MAX_HOLD   = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  vs_residual_ram_arbiter_if.slave bus,
  output logic                     ram_write_enable,
  output logic [ADDR_WIDTH-1:0]    ram_write_addr,
  output logic [DATA_WIDTH-1:0]    ram_write_data,
  output logic [ADDR_WIDTH-1:0]    ram_read_addr,
  input  logic [DATA_WIDTH-1:0]    ram_read_data
);
  localparam logic [NUM_REQ-1:0] GNT_ONE = NUM_REQ'(1);

  arb_state_t            state;
  logic [NUM_REQ-1:0]    gnt_q;
  logic [NUM_REQ-1:0]    rvalid_q;
  logic [NUM_REQ-1:0]    owner_cmd;
  logic [ARB_IDX_W-1:0]  last_owner;
  logic [ARB_IDX_W-1:0]  owner_idx;
  logic [ARB_IDX_W-1:0]  pick_idx;
  logic                  pick_valid;
  logic                  cmd;
  logic                  handover;
  logic                  force_release;
  logic [ADDR_WIDTH-1:0] owner_addr;
  logic [DATA_WIDTH-1:0] owner_wdata;

  vs_rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req        (bus.req),
    .last_owner (last_owner),
    .winner     (pick_idx),
    .valid      (pick_valid)
  );

  assign owner_idx = onehot_to_index(ARB_MAX_REQ'(gnt_q));
  assign owner_cmd = gnt_q & bus.req;
  assign cmd       = |owner_cmd;
  assign handover  = (state == ARB_OWNED) && (!cmd || force_release);

  always_comb begin
    owner_addr  = '0;
    owner_wdata = '0;
    if (|gnt_q) begin
      owner_addr  = bus.req_addr[owner_idx*ADDR_WIDTH +: ADDR_WIDTH];
      owner_wdata = bus.req_wdata[owner_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ARB_IDLE;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      last_owner <= ARB_IDX_W'(NUM_REQ - 1);
    end else begin
      // read tag follows the issuer, not the current grant, so handover stays safe
      rvalid_q <= owner_cmd & ~bus.req_we;
      if (state == ARB_IDLE || handover) begin
        if (pick_valid) begin
          gnt_q      <= GNT_ONE << pick_idx;
          last_owner <= pick_idx;
          state      <= ARB_OWNED;
        end else begin
          gnt_q <= '0;
          state <= ARB_IDLE;
        end
      end
    end
  end

`ifdef VS_RESIDUAL_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0]  hold_cnt;
  logic [NUM_REQ-1:0] preempt_q;

  assign force_release = cmd && (hold_cnt >= HOLD_W'(MAX_HOLD - 1)) && |(bus.req & ~gnt_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_cnt  <= '0;
      preempt_q <= '0;
    end else begin
      if (force_release) preempt_q <= preempt_q | gnt_q;
      if (state != ARB_OWNED || handover) hold_cnt <= '0;
      else if (cmd && hold_cnt != HOLD_W'(MAX_HOLD)) hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign bus.preempt_err = preempt_q;
`else
  assign force_release   = 1'b0;
  assign bus.preempt_err = '0;
`endif

  assign bus.gnt          = gnt_q;
  assign bus.rvalid       = rvalid_q;
  assign bus.rdata        = ram_read_data;
  assign ram_write_enable = |(owner_cmd & bus.req_we);
  assign ram_write_addr   = owner_addr;
  assign ram_write_data   = owner_wdata;
  assign ram_read_addr    = owner_addr;
endmodule

// File: tb/tb_vs_residual_ram_arbiter.sv
// tb/tb_vs_residual_ram_arbiter.sv - self-checking bench for vs_residual_ram_arbiter
module tb_vs_residual_ram_arbiter;
  localparam int N    = 3;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int MAXH = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          ram_fill;
  logic          ram_write_enable;
  logic [AW-1:0] ram_write_addr;
  logic [DW-1:0] ram_write_data;
  logic [AW-1:0] ram_read_addr;
  logic [DW-1:0] ram_read_data;
  logic [DW-1:0] ram [256];

  always #5 clock = ~clock;

  vs_residual_ram_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  vs_residual_ram_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(MAXH)) dut (
    .clock            (clock),
    .reset            (reset),
    .bus              (bus),
    .ram_write_enable (ram_write_enable),
    .ram_write_addr   (ram_write_addr),
    .ram_write_data   (ram_write_data),
    .ram_read_addr    (ram_read_addr),
    .ram_read_data    (ram_read_data)
  );

  function automatic logic [DW-1:0] pat(input int i);
    return 32'hA500_0000 ^ DW'(i * 32'h0001_0203);
  endfunction

  always @(posedge clock) begin
    if (ram_fill) begin
      for (int i = 0; i < 256; i++) ram[i] <= pat(i);
    end else if (ram_write_enable) begin
      ram[ram_write_addr] <= ram_write_data;
    end
    ram_read_data <= ram[ram_read_addr];
  end

  int total, bad;

  // reference model: who owns the RAM, whose turn is next, and what RAM should hold
  int            m_owner, m_last, m_hold;
  logic [N-1:0]  m_rvalid, m_preempt;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] m_mem [256];

  logic [N-1:0]  obs_gnt, obs_rvalid, obs_preempt;
  logic          obs_we;
  logic [AW-1:0] obs_waddr;
  logic [DW-1:0] obs_wdata, obs_rdata;

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int i = (last + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = N - 1; m_hold = 0;
    m_rvalid = '0; m_preempt = '0; m_rdata = '0;
  endtask

  task automatic drive_cycle(input logic [N-1:0] r, input logic [N-1:0] we,
                             input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
    logic [N-1:0]  e_gnt, nrv;
    logic          cmd, e_we, force_rel;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    int            prev, pick;
    @(negedge clock);
    bus.req = r; bus.req_we = we; bus.req_addr = a; bus.req_wdata = d;
    #1;
    e_gnt = '0; e_addr = '0; e_wd = '0; cmd = 1'b0; e_we = 1'b0;
    if (m_owner >= 0) begin
      e_gnt[m_owner] = 1'b1;
      cmd    = r[m_owner];
      e_we   = cmd && we[m_owner];
      e_addr = a[m_owner*AW +: AW];
      e_wd   = d[m_owner*DW +: DW];
    end
    obs_gnt = bus.gnt; obs_rvalid = bus.rvalid; obs_preempt = bus.preempt_err;
    obs_we = ram_write_enable; obs_waddr = ram_write_addr; obs_wdata = ram_write_data;
    obs_rdata = bus.rdata;

    total++;
    if (bus.gnt !== e_gnt) begin bad++; $display("FAIL gnt got=%b exp=%b t=%0t", bus.gnt, e_gnt, $time); end
    total++;
    if (bus.rvalid !== m_rvalid) begin bad++; $display("FAIL rvalid got=%b exp=%b t=%0t", bus.rvalid, m_rvalid, $time); end
    if (m_rvalid != '0) begin
      total++;
      if (bus.rdata !== m_rdata) begin bad++; $display("FAIL rdata got=%h exp=%h t=%0t", bus.rdata, m_rdata, $time); end
    end
    total++;
    if (ram_write_enable !== e_we) begin bad++; $display("FAIL write_enable got=%b exp=%b t=%0t", ram_write_enable, e_we, $time); end
    if (e_we) begin
      total++;
      if (ram_write_addr !== e_addr || ram_write_data !== e_wd) begin
        bad++; $display("FAIL write_cmd got=%h/%h exp=%h/%h t=%0t", ram_write_addr, ram_write_data, e_addr, e_wd, $time);
      end
    end
    total++;
    if (ram_read_addr !== e_addr) begin bad++; $display("FAIL read_addr got=%h exp=%h t=%0t", ram_read_addr, e_addr, $time); end
    total++;
    if (bus.preempt_err !== m_preempt) begin bad++; $display("FAIL preempt_err got=%b exp=%b t=%0t", bus.preempt_err, m_preempt, $time); end

    nrv = '0;
    if (cmd) begin
      if (we[m_owner]) m_mem[e_addr] = e_wd;
      else begin nrv[m_owner] = 1'b1; m_rdata = m_mem[e_addr]; end
    end
    force_rel = 1'b0;
`ifdef VS_RESIDUAL_ARB_TIMEOUT_EN
    if (cmd && m_hold + 1 >= MAXH && (r & ~e_gnt) != '0) force_rel = 1'b1;
`endif
    prev = m_owner;
    if (m_owner < 0 || !cmd || force_rel) begin
      if (force_rel) m_preempt[m_owner] = 1'b1;
      pick = rr_pick(r, m_last);
      if (pick >= 0) begin m_owner = pick; m_last = pick; end
      else m_owner = -1;
    end
    if (m_owner != prev || m_owner < 0) m_hold = 0;
    else if (cmd && m_hold < MAXH) m_hold++;
    m_rvalid = nrv;
  endtask

  task automatic idle_cycle();
    drive_cycle('0, '0, '0, '0);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    #1;
    total++;
    if (bus.rvalid !== m_rvalid) begin bad++; $display("FAIL pre_reset_rvalid got=%b exp=%b", bus.rvalid, m_rvalid); end
    #1 reset = 1'b1;
    #1;
    total++;
    if (bus.gnt !== '0) begin bad++; $display("FAIL reset_gnt got=%b exp=000", bus.gnt); end
    total++;
    if (bus.rvalid !== '0) begin bad++; $display("FAIL reset_rvalid got=%b exp=000", bus.rvalid); end
    total++;
    if (bus.preempt_err !== '0) begin bad++; $display("FAIL reset_preempt got=%b exp=000", bus.preempt_err); end
    bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    idle_cycle();
    total++;
    if (obs_we !== 1'b0 || obs_gnt !== '0) begin bad++; $display("FAIL idle_after_reset got=%b/%b exp=0/000", obs_we, obs_gnt); end
  endtask

  task automatic test_single_write();
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] d;
    a = '0; d = '0;
    a[0 +: AW] = 8'd5; d[0 +: DW] = 32'h0001_0000;
    drive_cycle(3'b001, 3'b001, a, d);
    drive_cycle(3'b001, 3'b001, a, d);
    total++;
    if (obs_gnt !== 3'b001 || obs_we !== 1'b1 || obs_waddr !== 8'd5 || obs_wdata !== 32'h0001_0000) begin
      bad++; $display("FAIL single_write got=%b/%b/%h/%h exp=001/1/05/00010000", obs_gnt, obs_we, obs_waddr, obs_wdata);
    end
    idle_cycle();
    idle_cycle();
  endtask

  task automatic test_round_robin();
    int cnt [N];
    int order [$];
    int cmds, gaps;
    logic [N-1:0] r, prev_gnt;
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] d;
    apply_reset();
    for (int i = 0; i < N; i++) cnt[i] = 0;
    cmds = 0; gaps = 0; prev_gnt = '0;
    for (int c = 0; c < 30; c++) begin
      for (int i = 0; i < N; i++) r[i] = (cnt[i] < 2);
      if (r == '0) break;
      for (int i = 0; i < N; i++) begin a[i*AW +: AW] = AW'(16 * i + cnt[i]); d[i*DW +: DW] = $urandom; end
      drive_cycle(r, '1, a, d);
      for (int i = 0; i < N; i++) if (obs_gnt[i] && r[i]) begin cnt[i]++; cmds++; end
      if (obs_gnt != '0 && obs_gnt != prev_gnt) begin
        for (int i = 0; i < N; i++) if (obs_gnt[i]) order.push_back(i);
      end
      if (c > 0 && obs_gnt == '0) gaps++;
      prev_gnt = obs_gnt;
    end
    idle_cycle();
    total++;
    if (cmds != 6) begin bad++; $display("FAIL rr_commands got=%0d exp=6", cmds); end
    total++;
    if (gaps != 0) begin bad++; $display("FAIL rr_idle_gaps got=%0d exp=0", gaps); end
    total++;
    if (order.size() != 3 || order[0] != 0 || order[1] != 1 || order[2] != 2) begin
      bad++; $display("FAIL rr_order got=%p exp=0,1,2", order);
    end
  endtask

  task automatic test_read_handover();
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] d;
    logic [DW-1:0]   v;
    apply_reset();
    v = $urandom;
    a = '0; d = '0;
    a[1*AW +: AW] = 8'd7; d[1*DW +: DW] = v;
    drive_cycle(3'b010, 3'b010, a, d);
    drive_cycle(3'b010, 3'b010, a, d);
    drive_cycle(3'b110, 3'b000, a, d);
    drive_cycle(3'b100, 3'b000, a, d);
    total++;
    if (obs_rvalid !== 3'b010 || obs_rdata !== v) begin
      bad++; $display("FAIL handover_read got=%b/%h exp=010/%h", obs_rvalid, obs_rdata, v);
    end
    drive_cycle(3'b100, 3'b000, a, d);
    total++;
    if (obs_gnt !== 3'b100) begin bad++; $display("FAIL handover_gnt got=%b exp=100", obs_gnt); end
    idle_cycle();
    idle_cycle();
  endtask

  task automatic test_reset_mid_burst();
    logic [N*AW-1:0] a;
    apply_reset();
    a = '0; a[0 +: AW] = 8'd3;
    drive_cycle(3'b001, 3'b000, a, '0);
    drive_cycle(3'b001, 3'b000, a, '0);
    apply_reset();
    drive_cycle(3'b111, 3'b000, a, '0);
    drive_cycle(3'b111, 3'b000, a, '0);
    total++;
    if (obs_gnt !== 3'b001) begin bad++; $display("FAIL restart_first_owner got=%b exp=001", obs_gnt); end
    idle_cycle();
    idle_cycle();
  endtask

  task automatic test_withdrawn_pulse();
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] d;
    logic            seen0;
    apply_reset();
    a = {8'd2, 8'd1, 8'd9}; d = {32'h2, 32'h1, 32'hDEAD};
    seen0 = 1'b0;
    drive_cycle(3'b010, 3'b011, a, d);
    drive_cycle(3'b011, 3'b011, a, d);
    drive_cycle(3'b010, 3'b011, a, d);
    seen0 |= obs_gnt[0] | (obs_we && obs_waddr == 8'd9);
    drive_cycle(3'b000, 3'b011, a, d);
    seen0 |= obs_gnt[0] | (obs_we && obs_waddr == 8'd9);
    idle_cycle();
    seen0 |= obs_gnt[0];
    total++;
    if (seen0 !== 1'b0) begin bad++; $display("FAIL withdrawn_req0 got=%b exp=0", seen0); end
  endtask

  task automatic test_timeout();
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] d;
    apply_reset();
    a = {8'd0, 8'd1, 8'd2}; d = {32'h0, 32'h11, 32'h22};
    drive_cycle(3'b001, 3'b011, a, d);
    for (int c = 0; c < 5; c++) drive_cycle(3'b011, 3'b011, a, d);
`ifdef VS_RESIDUAL_ARB_TIMEOUT_EN
    total++;
    if (obs_gnt !== 3'b010 || obs_preempt !== 3'b001) begin
      bad++; $display("FAIL timeout_preempt got=%b/%b exp=010/001", obs_gnt, obs_preempt);
    end
`else
    total++;
    if (obs_gnt !== 3'b001 || obs_preempt !== 3'b000) begin
      bad++; $display("FAIL unbounded_hold got=%b/%b exp=001/000", obs_gnt, obs_preempt);
    end
`endif
    idle_cycle();
    idle_cycle();
  endtask

  task automatic test_random();
    logic [N-1:0]    r, we;
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] d;
    apply_reset();
    r = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) r[i] = ~r[i];
        a[i*AW +: AW] = AW'($urandom_range(0, 15));
        d[i*DW +: DW] = $urandom;
      end
      we = N'($urandom);
      drive_cycle(r, we, a, d);
    end
    idle_cycle();
    idle_cycle();
  endtask

  initial begin
    reset = 1'b1; ram_fill = 1'b1;
    bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
    total = 0; bad = 0;
    model_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = pat(i);
    repeat (2) @(posedge clock);
    @(negedge clock);
    ram_fill = 1'b0; reset = 1'b0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_read_handover();
    test_reset_mid_burst();
    test_withdrawn_pulse();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
